// File: rtl/fetch_stall_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stall_buffer
//  Description : Small FIFO between IMEM and the IF/ID register. It applies
//                the hazard unit's stall and flush controls, bypasses words
//                straight into ID when empty, and inserts NOP bubbles.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stall_buffer #(
  parameter int               DEPTH    = 2,
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       imem_valid,
  input  logic [XLEN-1:0]            imem_pc,
  input  logic [XLEN-1:0]            imem_inst,
  output logic                       imem_ready,
  input  logic                       PC_EN_IF,
  input  logic                       reg_FD_stall,
  input  logic                       reg_FD_flush,
  output logic [XLEN-1:0]            inst_ID,
  output logic [XLEN-1:0]            PC_ID,
  output logic                       valid_ID,
  output logic [$clog2(DEPTH):0]     buf_count,
  output logic [15:0]                bubble_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  // FIFO storage and bookkeeping
  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;

  // ID register
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [15:0]       bubble_q, bubble_d;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_fifo_wr;
  logic w_unused;

  // PC_EN_IF only throttles IMEM upstream; words already offered are still taken
  assign w_unused = PC_EN_IF;

  // Ready looks only at registered occupancy and flush, never at this cycle's pop
  assign w_full     = (count_q == C_DEPTH);
  assign imem_ready = rstn & ~w_full & ~reg_FD_flush;
  assign w_push     = imem_valid & imem_ready;
  assign w_pop      = ~reg_FD_flush & ~reg_FD_stall & (count_q != '0);
  assign w_bypass   = ~reg_FD_flush & ~reg_FD_stall & (count_q == '0) & w_push;
  assign w_fifo_wr  = w_push & ~w_bypass;

  // Next-state for pointers, occupancy and the ID register in priority order
  always_comb begin
    rd_d     = rd_q;
    wr_d     = wr_q;
    count_d  = count_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    bubble_d = bubble_q;

    if (reg_FD_flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      inst_d  = NOP_INST;
      pc_d    = '0;
      valid_d = 1'b0;
    end else begin
      if (w_fifo_wr) begin
        wr_d = wr_q + PW'(1);
      end
      if (w_pop) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(w_fifo_wr) - CW'(w_pop);

      if (reg_FD_stall) begin
        // ID holds; the FIFO may still fill behind it
      end else if (w_pop) begin
        pc_d    = mem_q[rd_q][2*XLEN-1:XLEN];
        inst_d  = mem_q[rd_q][XLEN-1:0];
        valid_d = 1'b1;
      end else if (w_bypass) begin
        pc_d    = imem_pc;
        inst_d  = imem_inst;
        valid_d = 1'b1;
      end else begin
        pc_d    = '0;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        if (bubble_q != 16'hFFFF) begin
          bubble_d = bubble_q + 16'd1;
        end
      end
    end
  end

  // Control and ID state, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      inst_q   <= NOP_INST;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end

  // FIFO payload; contents are meaningless until counted, so no reset needed
  always_ff @(posedge clk) begin
    if (w_fifo_wr && rstn) begin
      mem_q[wr_q] <= {imem_pc, imem_inst};
    end
  end

  assign inst_ID    = inst_q;
  assign PC_ID      = pc_q;
  assign valid_ID   = valid_q;
  assign buf_count  = count_q;
  assign bubble_cnt = bubble_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stall_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stall_buffer
//  Description : Scoreboard bench for fetch_stall_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stall_buffer;

  localparam int          DEPTH = 2;
  localparam int          XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_valid;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        imem_ready;
  logic        PC_EN_IF;
  logic        reg_FD_stall;
  logic        reg_FD_flush;
  logic [31:0] inst_ID;
  logic [31:0] PC_ID;
  logic        valid_ID;
  logic [1:0]  buf_count;
  logic [15:0] bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: queue of accepted-but-not-yet-issued words plus ID register
  logic [63:0] sb[$];
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          m_bub;

  fetch_stall_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_valid   (imem_valid),
    .imem_pc      (imem_pc),
    .imem_inst    (imem_inst),
    .imem_ready   (imem_ready),
    .PC_EN_IF     (PC_EN_IF),
    .reg_FD_stall (reg_FD_stall),
    .reg_FD_flush (reg_FD_flush),
    .inst_ID      (inst_ID),
    .PC_ID        (PC_ID),
    .valid_ID     (valid_ID),
    .buf_count    (buf_count),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 1'b0;
    m_inst  = NOP;
    m_pc    = '0;
    m_bub   = 0;
  endtask

  // One clock: check ready, advance the model across the edge, check outputs
  task automatic step(input bit do_chk, output bit acc);
    logic [63:0] w;
    bit          exp_rdy;
    bit          push;
    #1;
    exp_rdy = !reg_FD_flush && (sb.size() < DEPTH);
    if (do_chk) check_eq("imem_ready", 64'(imem_ready), 64'(exp_rdy));
    push = imem_valid && exp_rdy;
    acc  = push;
    @(posedge clk);
    if (reg_FD_flush) begin
      sb.delete();
      m_valid = 1'b0;
      m_inst  = NOP;
      m_pc    = '0;
    end else if (reg_FD_stall) begin
      if (push) sb.push_back({imem_pc, imem_inst});
    end else begin
      if (push) sb.push_back({imem_pc, imem_inst});
      if (sb.size() > 0) begin
        w       = sb.pop_front();
        m_valid = 1'b1;
        m_pc    = w[63:32];
        m_inst  = w[31:0];
      end else begin
        m_valid = 1'b0;
        m_inst  = NOP;
        m_pc    = '0;
        if (m_bub < 65535) m_bub++;
      end
    end
    #1;
    if (do_chk) begin
      check_eq("valid_ID",   64'(valid_ID),   64'(m_valid));
      check_eq("inst_ID",    64'(inst_ID),    64'(m_inst));
      check_eq("PC_ID",      64'(PC_ID),      64'(m_pc));
      check_eq("buf_count",  64'(buf_count),  64'(sb.size()));
      check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(valid_ID),   64'(0));
    check_eq({tag, "_inst"},  64'(inst_ID),    64'(NOP));
    check_eq({tag, "_pc"},    64'(PC_ID),      64'(0));
    check_eq({tag, "_count"}, 64'(buf_count),  64'(0));
    check_eq({tag, "_bub"},   64'(bubble_cnt), 64'(0));
    check_eq({tag, "_ready"}, 64'(imem_ready), 64'(0));
  endtask

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] pcs [3];
    logic [31:0] next_pc;

    rstn = 1'b0; imem_valid = 1'b0; imem_pc = '0; imem_inst = '0;
    PC_EN_IF = 1'b1; reg_FD_stall = 1'b0; reg_FD_flush = 1'b0;
    model_reset();

    // Reset state and initial bubbles
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rstn = 1'b1;
    repeat (3) step(1'b1, acc);
    check_eq("bubble3", 64'(bubble_cnt), 64'(3));

    // Bypass path
    imem_valid = 1'b1; imem_pc = 32'h100; imem_inst = 32'h00500093;
    step(1'b1, acc);
    imem_valid = 1'b0;
    check_eq("bypass_acc", 64'(acc), 64'(1));
    check_eq("bypass_pc", 64'(PC_ID), 64'(32'h100));
    check_eq("bypass_cnt", 64'(buf_count), 64'(0));

    // Stall fill, then drain in order
    pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10C;
    idx = 0;
    reg_FD_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      imem_valid = (idx < 3);
      imem_pc    = pcs[idx % 3];
      imem_inst  = 32'h00100113 + 32'(idx);
      step(1'b1, acc);
      if (acc) idx++;
      check_eq("stall_hold_pc", 64'(PC_ID), 64'(32'h100));
    end
    check_eq("stall_full_cnt", 64'(buf_count), 64'(2));
    check_eq("stall_pending", 64'(idx), 64'(2));
    reg_FD_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      imem_valid = (idx < 3);
      imem_pc    = pcs[idx % 3];
      imem_inst  = 32'h00100113 + 32'(idx);
      step(1'b1, acc);
      if (acc) idx++;
      check_eq("drain_pc", 64'(PC_ID), 64'(pcs[k]));
    end
    imem_valid = 1'b0;
    step(1'b1, acc);

    // Flush beats stall; offered word must survive to the next cycle
    reg_FD_stall = 1'b1;
    imem_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      imem_pc = 32'h300 + 32'(4 * k); imem_inst = 32'h00200093 + 32'(k);
      step(1'b1, acc);
    end
    imem_pc = 32'h308; imem_inst = 32'h00300093;
    reg_FD_flush = 1'b1;
    step(1'b1, acc);
    check_eq("flush_acc", 64'(acc), 64'(0));
    check_eq("flush_valid", 64'(valid_ID), 64'(0));
    check_eq("flush_cnt", 64'(buf_count), 64'(0));
    reg_FD_flush = 1'b0; reg_FD_stall = 1'b0;
    step(1'b1, acc);
    imem_valid = 1'b0;
    check_eq("post_flush_pc", 64'(PC_ID), 64'(32'h308));

    // Randomised traffic with occasional stall, flush and PC freeze
    next_pc = 32'h1000;
    for (int k = 0; k < 80; k++) begin
      imem_valid   = ($urandom_range(0, 3) != 0);
      imem_pc      = next_pc;
      imem_inst    = $urandom;
      reg_FD_stall = ($urandom_range(0, 3) == 0);
      reg_FD_flush = ($urandom_range(0, 15) == 0);
      PC_EN_IF     = ($urandom_range(0, 4) != 0);
      step(1'b1, acc);
      if (acc) next_pc = next_pc + 32'd4;
    end
    imem_valid = 1'b0; reg_FD_stall = 1'b0; reg_FD_flush = 1'b0; PC_EN_IF = 1'b1;

    // Asynchronous reset mid-operation with two buffered words
    reg_FD_stall = 1'b1; imem_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      imem_pc = 32'h400 + 32'(4 * k); imem_inst = 32'h00400093 + 32'(k);
      step(1'b1, acc);
    end
    imem_valid = 1'b0;
    check_eq("pre_arst_cnt", 64'(buf_count), 64'(2));
    #3 rstn = 1'b0;
    #1 check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    @(negedge clk) rstn = 1'b1;
    reg_FD_stall = 1'b0;
    imem_valid = 1'b1; imem_pc = 32'h500; imem_inst = 32'h00600093;
    step(1'b1, acc);
    imem_valid = 1'b0;
    check_eq("arst_bypass_pc", 64'(PC_ID), 64'(32'h500));
    check_eq("arst_bypass_cnt", 64'(buf_count), 64'(0));

    // Bubble counter saturation
    for (int k = 0; k < 70000; k++) step(1'b0, acc);
    check_eq("bubble_sat", 64'(bubble_cnt), 64'(16'hFFFF));
    step(1'b1, acc);
    check_eq("bubble_nowrap", 64'(bubble_cnt), 64'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stall_buffer.md
Name: fetch_stall_buffer

Overview:
- Decoupling buffer between instruction memory and the IF/ID boundary.
- Acts as the receiving end of the hazard unit's fetch-side controls (PC_EN_IF, reg_FD_stall, reg_FD_flush) and applies them to the instruction stream.
- Accepts {pc, inst} words from IMEM over a valid/ready handshake, queues them in a small FIFO, and presents exactly one instruction per cycle to ID.
- Inserts NOP bubbles on flush or when the buffer is empty.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, 2..8.
- XLEN, 32, PC and instruction width.
- NOP_INST, 32'h00000013, encoding injected on bubbles (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rstn  input  1  asynchronous reset, active-low.
- imem_valid  input  1  IMEM word valid this cycle.
- imem_pc  input  XLEN  PC of the offered word.
- imem_inst  input  XLEN  offered instruction.
- imem_ready  output  1  buffer accepts the offered word this cycle.
- PC_EN_IF  input  1  hazard unit PC enable; low means the PC is frozen.
- reg_FD_stall  input  1  hold the ID-stage instruction.
- reg_FD_flush  input  1  discard the ID instruction and all buffered words (branch taken).
- inst_ID  output  XLEN  instruction presented to decode.
- PC_ID  output  XLEN  PC of inst_ID.
- valid_ID  output  1  inst_ID is a real instruction, not a bubble.
- buf_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- bubble_cnt  output  16  saturating count of empty-buffer bubbles.

Behaviour:
- Reset (rstn low, asynchronous, any time including mid-transfer):
  - count=0, read/write pointers=0.
  - inst_ID=NOP_INST, PC_ID=0, valid_ID=0, bubble_cnt=0.
  - imem_ready=0 while reset is asserted.
- imem_ready = rstn & ~full & ~reg_FD_flush.
  - Combinational on registered count and flush only; it does not depend on the same-cycle pop.
- push = imem_valid & imem_ready.
- PC_EN_IF does not gate push. A word already in flight is still captured, and the hazard unit's freeze throttles IMEM upstream.
- ID register update each rising edge, in priority order:
  1. reg_FD_flush:
     - inst_ID<=NOP_INST, PC_ID<=0, valid_ID<=0.
     - FIFO cleared (count=0, pointers=0).
     - The same-cycle IMEM word is not accepted, because ready is low.
     - Flush beats stall when both are asserted.
  2. reg_FD_stall:
     - inst_ID, PC_ID and valid_ID hold; no pop.
     - push still writes the FIFO if not full.
  3. count>0:
     - Pop the head into inst_ID/PC_ID with valid_ID<=1.
     - A same-cycle push writes the tail, so count is unchanged.
  4. count==0 and push (bypass):
     - The incoming word loads directly into the ID register with valid_ID<=1.
     - It is not written to the FIFO, and count stays 0.
  5. Otherwise (empty, no push):
     - inst_ID<=NOP_INST, PC_ID<=0, valid_ID<=0.
     - bubble_cnt increments and saturates at 16'hFFFF.
- Latency:
  - Empty buffer, not stalled: a word reaches ID one cycle after acceptance (bypass).
  - Non-empty buffer: the word waits behind older entries, in strict FIFO order.
- Occupancy arithmetic:
  - count is the next count = count + (push & ~bypass) - pop.
  - It never exceeds DEPTH and never underflows.
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH).
- Stall with a full FIFO: imem_ready=0 and there is no data loss; the word stays offered by IMEM.
- buf_count reflects the registered count.

Test Plan:
- Reset and bubbles: release rstn with imem_valid=0 for 3 cycles. Required: valid_ID=0, inst_ID=32'h00000013, bubble_cnt=3.
- Bypass path: empty buffer, offer pc=0x100/inst=0x00500093 for one cycle. Required: imem_ready=1; next cycle inst_ID=0x00500093, PC_ID=0x100, valid_ID=1, buf_count=0.
- Stall fill and drain: hold reg_FD_stall for 4 cycles while streaming pc 0x104, 0x108, 0x10C.
  - During the stall, the ID register holds.
  - buf_count reaches 2, after which imem_ready=0 and 0x10C stays pending.
  - After release, ID shows 0x104, 0x108, 0x10C in order on consecutive cycles.
- Flush over stall: buffer holds 2 entries, assert reg_FD_flush and reg_FD_stall together with imem_valid=1.
  - In that cycle, imem_ready=0.
  - Next cycle: valid_ID=0, inst_ID=NOP, buf_count=0, and the offered word is not consumed.
- Async reset mid-operation: drop rstn between clock edges with buf_count=2. Required: outputs go to reset values immediately, and after release the first accepted word takes the bypass path.
- Saturation: force 70000 consecutive empty cycles. Required: bubble_cnt=16'hFFFF with no wrap.
